// File: rtl/mem_rd_arbiter.sv
// Two-requester read-port arbiter: one outstanding read, round-robin or fixed priority,
// with a lock that lets the last winner keep the port across consecutive reads.
module mem_rd_arbiter #(
  parameter int DATA_LEN  = 32,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  // requester 0 (icache refill)
  input  logic                m0_arvalid,
  output logic                m0_arready,
  input  logic [DATA_LEN-1:0] m0_raddr,
  input  logic                m0_lock,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  output logic [2:0]          m0_rresp,
  output logic [DATA_LEN-1:0] m0_rdata,
  // requester 1 (LSU / dcache)
  input  logic                m1_arvalid,
  output logic                m1_arready,
  input  logic [DATA_LEN-1:0] m1_raddr,
  input  logic                m1_lock,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  output logic [2:0]          m1_rresp,
  output logic [DATA_LEN-1:0] m1_rdata,
  // slave read port
  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [DATA_LEN-1:0] s_raddr,
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic [2:0]          s_rresp,
  input  logic [DATA_LEN-1:0] s_rdata,
  // current FSM state, for checkers and debug
  output logic [1:0]          o_dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both
  // high; valid never waits on ready, and address/valid stay stable until accepted.

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic                r_gnt;
  logic                r_last_gnt;
  logic                r_lock_hold;
  logic                r_s_arvalid;
  logic [DATA_LEN-1:0] r_s_raddr;

  logic [1:0]          w_arvalid;
  logic [1:0]          w_lock;
  logic [1:0]          w_rready;
  logic                w_win;
  logic                w_win_vld;
  logic                w_ar_hs;
  logic                w_r_hs;
  logic                w_s_rready;
  logic                w_lock_release;

  assign w_arvalid = {m1_arvalid, m0_arvalid};
  assign w_lock    = {m1_lock, m0_lock};
  assign w_rready  = {m1_rready, m0_rready};

  // While locked only the previous winner is eligible, even if the other side is waiting.
  always_comb begin
    w_win     = 1'b0;
    w_win_vld = 1'b0;
    if (r_lock_hold) begin
      w_win     = r_last_gnt;
      w_win_vld = w_arvalid[r_last_gnt];
    end else if (w_arvalid == 2'b11) begin
      w_win     = FIXED_PRI ? 1'b0 : ~r_last_gnt;
      w_win_vld = 1'b1;
    end else begin
      w_win     = w_arvalid[1];
      w_win_vld = |w_arvalid;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ar_hs     = 1'b0;
    w_r_hs      = 1'b0;
    w_s_rready  = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_win_vld) begin
          w_ar_hs     = 1'b1;
          w_state_nxt = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (r_s_arvalid && s_arready) begin
          w_state_nxt = ARB_DATA;
        end
      end
      ARB_DATA: begin
        w_s_rready = w_rready[r_gnt];
        if (s_rvalid && w_s_rready) begin
          w_r_hs      = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // A locked requester that drops lock while idle gives up the port without a transfer.
  assign w_lock_release = (r_state == ARB_IDLE) && r_lock_hold &&
                          !w_arvalid[r_last_gnt] && !w_lock[r_last_gnt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB_IDLE;
      r_gnt       <= 1'b0;
      r_last_gnt  <= 1'b1;
      r_lock_hold <= 1'b0;
      r_s_arvalid <= 1'b0;
      r_s_raddr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ar_hs) begin
        r_gnt       <= w_win;
        r_s_raddr   <= w_win ? m1_raddr : m0_raddr;
        r_s_arvalid <= 1'b1;
      end else if (r_s_arvalid && s_arready) begin
        r_s_arvalid <= 1'b0;
      end
      if (w_r_hs) begin
        r_last_gnt  <= r_gnt;
        r_lock_hold <= w_lock[r_gnt];
      end else if (w_lock_release) begin
        r_lock_hold <= 1'b0;
      end
    end
  end

  assign m0_arready = w_ar_hs & ~w_win;
  assign m1_arready = w_ar_hs & w_win;

  assign s_arvalid = r_s_arvalid;
  assign s_raddr   = r_s_raddr;
  assign s_rready  = w_s_rready;

  assign m0_rvalid = (r_state == ARB_DATA) && !r_gnt && s_rvalid;
  assign m1_rvalid = (r_state == ARB_DATA) && r_gnt && s_rvalid;

  // Data and response are broadcast; only rvalid tells a requester the beat is its own.
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m1_rresp = s_rresp;

  assign o_dbg_state = r_state;

endmodule
